sim_halt_ctrl: RTL and testbench
================================

# sim_halt_ctrl

Parametrised run/halt controller inserted between the instruction memory and the processor's fetch port in the SoC top. It forwards fetched instructions, detects end-of-program instructions (ebreak, optionally ecall) and a watchdog timeout, then freezes the fetch stream by repeating the trigger word. After a configurable pipeline-drain period it raises a done flag, and it reports halt cause, halt PC, cycle count and fetch count to the testbench.

## Interface
- DRAIN_CYCLES, 5, cycles the processor pipeline is given to retire in-flight instructions after the trigger; 0 allowed.
- TIMEOUT_CYCLES, 100000, watchdog limit in cycles; 0 disables the watchdog.
- HALT_ON_ECALL, 0, 1 = ecall (32'h0000_0073) is also a halt trigger.
- CNT_WIDTH, 32, width of both performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- ip_inst_addr  in  32  PC driven by the processor to imem.
- ip_inst_valid  in  1  imem valid for ip_inst_from_imem.
- ip_inst_from_imem  in  32  instruction word from imem.
- op_inst_to_proc  out  32  instruction word delivered to the processor.
- op_halted  out  1  trigger or timeout has occurred.
- op_done  out  1  drain complete; simulation may stop.
- op_status  out  2  00 running, 01 ebreak, 10 ecall, 11 timeout.
- op_halt_pc  out  32  ip_inst_addr captured in the trigger cycle (timeout: PC in the timeout cycle).
- op_cycle_count  out  CNT_WIDTH  cycles spent in RUN and DRAIN.
- op_fetch_count  out  CNT_WIDTH  valid fetches seen in RUN.

## Operation
- States: RUN, DRAIN, DONE. Reset places the block in RUN.
- RUN:
  - op_inst_to_proc = ip_inst_from_imem (combinational pass-through).
  - A trigger is ip_inst_valid=1 with the word equal to 32'h0010_0073, or, when HALT_ON_ECALL=1, equal to 32'h0000_0073.
  - On a trigger, the word passes through in the same cycle.
  - At the clock edge, the block latches held_word = trigger word, status (01/10) and halt_pc, loads drain_cnt = DRAIN_CYCLES, and moves to DRAIN. If DRAIN_CYCLES=0, it moves directly to DONE.
  - Timeout: TIMEOUT_CYCLES≠0, no trigger, and op_cycle_count == TIMEOUT_CYCLES-1. Behaves like a trigger with held_word = 32'h0010_0073 and status 11. The imem word in that cycle still passes through.
  - Trigger and timeout in the same cycle: the trigger wins, and status reflects the instruction.
  - ip_inst_valid=0: the word is forwarded unchanged, is not counted, and is never a trigger.
- DRAIN:
  - op_inst_to_proc = held_word; imem is ignored.
  - drain_cnt decrements each cycle. When drain_cnt==1, the block moves to DONE at the next edge.
  - Further triggers and timeouts are ignored.
- DONE:
  - op_inst_to_proc = held_word indefinitely; counters are frozen.
  - The block leaves DONE only by reset.
- Counters:
  - op_cycle_count increments every cycle in RUN and DRAIN and saturates at all-ones.
  - op_fetch_count increments in RUN on each cycle with ip_inst_valid=1, including the trigger cycle, and saturates.
- Outputs: op_halted = (state≠RUN). op_done = (state==DONE). op_status and op_halt_pc are registered and hold until reset.
- Reset asserted mid-operation (any state): asynchronously clears all registers. The block returns to RUN with pass-through restored in the same cycle.

## Timing
- Reset values: op_halted=0, op_done=0, op_status=00, op_halt_pc=0, op_cycle_count=0, op_fetch_count=0. op_inst_to_proc = ip_inst_from_imem.
- Pass-through latency is 0 cycles; the block adds no registers in the fetch path while in RUN.
- Trigger in cycle T:
  - op_halted, op_status and op_halt_pc are valid from cycle T+1.
  - held_word is driven from T+1.
  - op_done first reads 1 in cycle T+1+DRAIN_CYCLES.
- op_cycle_count reads N in the N-th cycle after reset deassertion (first cycle = 0). It freezes at its value on DONE entry.
- Timeout with TIMEOUT_CYCLES=K: timeout cycle is K-1; op_halted=1 from cycle K.
- drain_cnt width: $clog2(DRAIN_CYCLES+1), minimum 1.

## Test plan
- Program 3 valid NOPs (32'h0000_0013) then ebreak at PC 0x0C, DRAIN_CYCLES=5 -> ebreak passes through in cycle 3; op_halted=1, op_status=01, op_halt_pc=0x0C in cycle 4; op_done=1 in cycle 9; op_fetch_count=4; op_inst_to_proc stays 32'h0010_0073 while imem drives 32'h0000_0013.
- ecall with HALT_ON_ECALL=0, then ebreak -> ecall forwarded with no halt; halt on ebreak with status 01. Repeat with HALT_ON_ECALL=1 -> halt on ecall, status 10, held word 32'h0000_0073.
- TIMEOUT_CYCLES=10 with an endless NOP stream -> op_halted=1 in cycle 10, op_status=11, output 32'h0010_0073. Same run with ebreak in cycle 9 -> status 01 (trigger beats timeout).
- DRAIN_CYCLES=0 -> op_halted and op_done both rise in cycle T+1. ebreak with ip_inst_valid=0 -> no halt and no fetch count.
- Reset pulsed low during DRAIN -> all outputs return to reset values immediately; the following program runs and halts normally.
- CNT_WIDTH=4 with TIMEOUT_CYCLES=0 and a 20-cycle NOP run -> both counters saturate at 4'hF with no wrap.

Source files
------------

// File: rtl/sim_halt_ctrl.sv
// Run/halt controller between imem and the processor fetch port: forwards
// instructions, freezes the fetch stream on ebreak/ecall/watchdog and reports halt info.
module sim_halt_ctrl #(
    parameter int DRAIN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int HALT_ON_ECALL  = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          ip_inst_addr,
    input  logic                 ip_inst_valid,
    input  logic [31:0]          ip_inst_from_imem,
    output logic [31:0]          op_inst_to_proc,
    output logic                 op_halted,
    output logic                 op_done,
    output logic [1:0]           op_status,
    output logic [31:0]          op_halt_pc,
    output logic [CNT_WIDTH-1:0] op_cycle_count,
    output logic [CNT_WIDTH-1:0] op_fetch_count
);

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam int          DW          = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0]        DRAIN_LOAD    = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t                 state_r;
    logic [31:0]            held_word_r;
    logic [1:0]             status_r;
    logic [31:0]            halt_pc_r;
    logic [DW-1:0]          drain_cnt_r;
    logic [CNT_WIDTH-1:0]   cycle_count_r;
    logic [CNT_WIDTH-1:0]   fetch_count_r;
    logic                   halted_r;
    logic                   done_r;

    logic                   trig_s;
    logic [1:0]             trig_status_s;
    logic                   timeout_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Decode halt triggers from the current imem word; ebreak takes priority.
    always_comb begin
        trig_s        = 1'b0;
        trig_status_s = 2'b00;
        if (ip_inst_valid && (ip_inst_from_imem == EBREAK_WORD)) begin
            trig_s        = 1'b1;
            trig_status_s = 2'b01;
        end else if ((HALT_ON_ECALL != 0) && ip_inst_valid && (ip_inst_from_imem == ECALL_WORD)) begin
            trig_s        = 1'b1;
            trig_status_s = 2'b10;
        end else begin
            trig_s        = 1'b0;
            trig_status_s = 2'b00;
        end
    end

    // Watchdog fires in the cycle the counter reaches its limit minus one.
    always_comb begin
        timeout_s = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && (cycle_count_r == TIMEOUT_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Fetch path: zero-latency pass-through in RUN, frozen trigger word afterwards.
    always_comb begin
        op_inst_to_proc = ip_inst_from_imem;
        if (state_r == ST_RUN) begin
            op_inst_to_proc = ip_inst_from_imem;
        end else begin
            op_inst_to_proc = held_word_r;
        end
    end

    // Run/drain/done state machine with halt capture and performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            held_word_r   <= 32'h0000_0000;
            status_r      <= 2'b00;
            halt_pc_r     <= 32'h0000_0000;
            drain_cnt_r   <= {DW{1'b0}};
            cycle_count_r <= {CNT_WIDTH{1'b0}};
            fetch_count_r <= {CNT_WIDTH{1'b0}};
            halted_r      <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_count_r <= sat_inc(cycle_count_r);
                    if (ip_inst_valid) begin
                        fetch_count_r <= sat_inc(fetch_count_r);
                    end
                    if (trig_s || timeout_s) begin
                        held_word_r <= trig_s ? ip_inst_from_imem : EBREAK_WORD;
                        status_r    <= trig_s ? trig_status_s : 2'b11;
                        halt_pc_r   <= ip_inst_addr;
                        drain_cnt_r <= DRAIN_LOAD;
                        halted_r    <= 1'b1;
                        if (DRAIN_CYCLES == 0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    cycle_count_r <= sat_inc(cycle_count_r);
                    drain_cnt_r   <= drain_cnt_r - DW'(1);
                    if (drain_cnt_r == DW'(1)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign op_halted      = halted_r;
    assign op_done        = done_r;
    assign op_status      = status_r;
    assign op_halt_pc     = halt_pc_r;
    assign op_cycle_count = cycle_count_r;
    assign op_fetch_count = fetch_count_r;

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// Directed bench for sim_halt_ctrl: three instances with different parameters
// share one stimulus stream; each scenario checks the instance(s) it targets.
module tb_sim_halt_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        valid = 1'b0;
    logic [31:0] word = 32'h0;

    logic [31:0] a_out, b_out, c_out, a_pc, b_pc, c_pc, a_cyc, a_fet, b_cyc, b_fet;
    logic        a_halted, a_done, b_halted, b_done, c_halted, c_done;
    logic [1:0]  a_status, b_status, c_status;
    logic [3:0]  c_cyc, c_fet;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sim_halt_ctrl #(.DRAIN_CYCLES(5), .TIMEOUT_CYCLES(10), .HALT_ON_ECALL(0), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .ip_inst_addr(addr), .ip_inst_valid(valid),
        .ip_inst_from_imem(word), .op_inst_to_proc(a_out), .op_halted(a_halted),
        .op_done(a_done), .op_status(a_status), .op_halt_pc(a_pc),
        .op_cycle_count(a_cyc), .op_fetch_count(a_fet));

    sim_halt_ctrl #(.DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .HALT_ON_ECALL(1), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset), .ip_inst_addr(addr), .ip_inst_valid(valid),
        .ip_inst_from_imem(word), .op_inst_to_proc(b_out), .op_halted(b_halted),
        .op_done(b_done), .op_status(b_status), .op_halt_pc(b_pc),
        .op_cycle_count(b_cyc), .op_fetch_count(b_fet));

    sim_halt_ctrl #(.DRAIN_CYCLES(2), .TIMEOUT_CYCLES(0), .HALT_ON_ECALL(0), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .ip_inst_addr(addr), .ip_inst_valid(valid),
        .ip_inst_from_imem(word), .op_inst_to_proc(c_out), .op_halted(c_halted),
        .op_done(c_done), .op_status(c_status), .op_halt_pc(c_pc),
        .op_cycle_count(c_cyc), .op_fetch_count(c_fet));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reset is released 1 time unit after a rising edge; that cycle is cycle 0.
    task automatic do_reset();
        reset = 1'b0;
        valid = 1'b0;
        word  = NOP;
        addr  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One cycle: drive inputs on the falling edge, sample 2 units later.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] a);
        @(negedge clk);
        valid = v;
        word  = w;
        addr  = a;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Three NOPs then ebreak at 0x0C, drain of 5
        do_reset();
        step(1'b1, NOP, 32'h0);
        check_val("rst_halted", {31'h0, a_halted}, 32'h0);
        check_val("rst_done", {31'h0, a_done}, 32'h0);
        check_val("rst_status", {30'h0, a_status}, 32'h0);
        check_val("rst_pc", a_pc, 32'h0);
        check_val("rst_cyc", a_cyc, 32'h0);
        check_val("rst_fetch", a_fet, 32'h0);
        check_val("rst_pass", a_out, NOP);
        step(1'b1, NOP, 32'h4);
        step(1'b1, NOP, 32'h8);
        step(1'b1, EBREAK, 32'hC);
        check_val("s1_trig_pass", a_out, EBREAK);
        check_val("s1_trig_halted", {31'h0, a_halted}, 32'h0);
        step(1'b1, NOP, 32'h10);
        check_val("s1_halted", {31'h0, a_halted}, 32'h1);
        check_val("s1_status", {30'h0, a_status}, 32'h1);
        check_val("s1_pc", a_pc, 32'hC);
        check_val("s1_held", a_out, EBREAK);
        check_val("s1_done_early", {31'h0, a_done}, 32'h0);
        for (int c = 5; c <= 8; c++) begin
            step(1'b1, NOP, 32'(4 * c));
            if (c == 8) check_val("s1_done_c8", {31'h0, a_done}, 32'h0);
        end
        step(1'b1, NOP, 32'h24);
        check_val("s1_done_c9", {31'h0, a_done}, 32'h1);
        check_val("s1_fetch", a_fet, 32'd4);
        check_val("s1_cyc", a_cyc, 32'd9);
        check_val("s1_hold_out", a_out, EBREAK);
        step(1'b1, NOP, 32'h28);
        check_val("s1_cyc_frozen", a_cyc, 32'd9);

        // ecall: forwarded by dut_a, halts dut_b (no drain)
        do_reset();
        step(1'b1, ECALL, 32'h0);
        check_val("s2_ecall_pass", a_out, ECALL);
        step(1'b1, EBREAK, 32'h4);
        check_val("s2_a_nohalt", {31'h0, a_halted}, 32'h0);
        check_val("s2_a_pass", a_out, EBREAK);
        check_val("s2_b_halted", {31'h0, b_halted}, 32'h1);
        check_val("s2_b_done", {31'h0, b_done}, 32'h1);
        check_val("s2_b_status", {30'h0, b_status}, 32'h2);
        check_val("s2_b_pc", b_pc, 32'h0);
        check_val("s2_b_held", b_out, ECALL);
        step(1'b1, NOP, 32'h8);
        check_val("s2_a_halted", {31'h0, a_halted}, 32'h1);
        check_val("s2_a_status", {30'h0, a_status}, 32'h1);
        check_val("s2_a_pc", a_pc, 32'h4);
        check_val("s2_b_held2", b_out, ECALL);

        // Endless NOPs: watchdog on dut_a, saturation on dut_c
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, NOP, 32'(4 * c));
            if (c == 9) check_val("s3_c9_halted", {31'h0, a_halted}, 32'h0);
            if (c == 9) check_val("s3_c9_pass", a_out, NOP);
            if (c == 10) check_val("s3_to_halted", {31'h0, a_halted}, 32'h1);
            if (c == 10) check_val("s3_to_status", {30'h0, a_status}, 32'h3);
            if (c == 10) check_val("s3_to_out", a_out, EBREAK);
            if (c == 10) check_val("s3_to_pc", a_pc, 32'h24);
            if (c == 14) check_val("s3_done_c14", {31'h0, a_done}, 32'h0);
            if (c == 15) check_val("s3_done_c15", {31'h0, a_done}, 32'h1);
            if (c == 15) check_val("s3_c_cyc15", {28'h0, c_cyc}, 32'hF);
            if (c == 16) check_val("s3_c_cyc_sat", {28'h0, c_cyc}, 32'hF);
            if (c == 19) check_val("s3_c_fet_sat", {28'h0, c_fet}, 32'hF);
            if (c == 19) check_val("s3_c_cyc_sat2", {28'h0, c_cyc}, 32'hF);
            if (c == 19) check_val("s3_b_nohalt", {31'h0, b_halted}, 32'h0);
        end

        // ebreak in the timeout cycle: trigger wins
        do_reset();
        for (int c = 0; c < 9; c++) step(1'b1, NOP, 32'(4 * c));
        step(1'b1, EBREAK, 32'h24);
        step(1'b1, NOP, 32'h28);
        check_val("s4_halted", {31'h0, a_halted}, 32'h1);
        check_val("s4_status", {30'h0, a_status}, 32'h1);
        check_val("s4_pc", a_pc, 32'h24);

        // Invalid ebreak: forwarded, no halt, not counted
        do_reset();
        step(1'b0, EBREAK, 32'h0);
        check_val("s5_pass", a_out, EBREAK);
        step(1'b1, NOP, 32'h4);
        check_val("s5_a_nohalt", {31'h0, a_halted}, 32'h0);
        check_val("s5_b_nohalt", {31'h0, b_halted}, 32'h0);
        check_val("s5_fetch0", a_fet, 32'h0);
        step(1'b1, NOP, 32'h8);
        check_val("s5_fetch1", a_fet, 32'h1);

        // Reset during DRAIN, then a normal run
        do_reset();
        step(1'b1, EBREAK, 32'h0);
        step(1'b1, NOP, 32'h4);
        step(1'b1, NOP, 32'h8);
        check_val("s6_drain_held", a_out, EBREAK);
        reset = 1'b0;
        #1;
        check_val("s6_rst_halted", {31'h0, a_halted}, 32'h0);
        check_val("s6_rst_status", {30'h0, a_status}, 32'h0);
        check_val("s6_rst_pc", a_pc, 32'h0);
        check_val("s6_rst_cyc", a_cyc, 32'h0);
        check_val("s6_rst_fetch", a_fet, 32'h0);
        check_val("s6_rst_pass", a_out, NOP);
        do_reset();
        step(1'b1, NOP, 32'h0);
        step(1'b1, EBREAK, 32'h4);
        step(1'b1, NOP, 32'h8);
        check_val("s6_halted", {31'h0, a_halted}, 32'h1);
        check_val("s6_status", {30'h0, a_status}, 32'h1);
        check_val("s6_pc", a_pc, 32'h4);
        for (int c = 3; c <= 7; c++) begin
            step(1'b1, NOP, 32'(4 * c));
            if (c == 6) check_val("s6_done_c6", {31'h0, a_done}, 32'h0);
            if (c == 7) check_val("s6_done_c7", {31'h0, a_done}, 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
